// File: rtl/anemo_pio_write_arbiter.sv
// Round-robin arbiter sharing the output PIO Avalon-MM slave between
// NUM_REQ requesters. Each grant performs one write, one read-back of
// address 0 with compare, an ack pulse, and an optional hold-off gap.
module anemo_pio_write_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 8,
  parameter int MIN_GAP = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        ack,
  output logic                      ack_err,
  output logic                      busy,
  output logic                      rb_error,
  output logic [7:0]                err_cnt,
  input  logic                      clr_err,
  output logic [1:0]                av_address,
  output logic                      av_chipselect,
  output logic                      av_write_n,
  output logic [31:0]               av_writedata,
  input  logic [31:0]               av_readdata
);

  localparam int          IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned NR = NUM_REQ;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_DONE,
    S_GAP
  } state_t;

  state_t              state_q;
  logic [IW-1:0]       rr_ptr_q;
  logic [IW-1:0]       gnt_q;
  logic [DATA_W-1:0]   data_q;
  logic                mis_q;
  logic [7:0]          gap_q;
  logic [NUM_REQ-1:0]  ack_q;
  logic                ack_err_q;
  logic                busy_q;
  logic                rb_error_q;
  logic [7:0]          err_cnt_q;
  logic                cs_q;
  logic                wn_q;
  logic [31:0]         wd_q;

  logic                grant_vld;
  logic [IW-1:0]       grant_idx;
  logic [DATA_W-1:0]   grant_data;
  logic [31:0]         wd_ext;
  logic                mismatch;
  logic [IW-1:0]       rr_next;
  logic                unused_rd;

  // Round-robin search: first set req bit starting at rr_ptr, wrapping.
  always_comb begin
    int unsigned idx;
    grant_vld = 1'b0;
    grant_idx = '0;
    idx       = 0;
    for (int unsigned i = 0; i < NR; i++) begin
      idx = 32'(rr_ptr_q) + i;
      if (idx >= NR) idx = idx - NR;
      if (!grant_vld && req[idx]) begin
        grant_vld = 1'b1;
        grant_idx = IW'(idx);
      end
    end
  end

  // Selected requester data, zero-extended copy for the bus, and compare.
  always_comb begin
    grant_data               = req_data[32'(grant_idx)*DATA_W +: DATA_W];
    wd_ext                   = '0;
    wd_ext[DATA_W-1:0]       = grant_data;
    mismatch                 = (av_readdata[DATA_W-1:0] != data_q);
    rr_next                  = (32'(gnt_q) == NR - 1) ? '0 : gnt_q + 1'b1;
  end

  // Bits of the read-back above DATA_W are deliberately ignored.
  assign unused_rd = ^av_readdata;

  // Transaction FSM with all bus and handshake outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      rr_ptr_q   <= '0;
      gnt_q      <= '0;
      data_q     <= '0;
      mis_q      <= 1'b0;
      gap_q      <= '0;
      ack_q      <= '0;
      ack_err_q  <= 1'b0;
      busy_q     <= 1'b0;
      rb_error_q <= 1'b0;
      err_cnt_q  <= '0;
      cs_q       <= 1'b0;
      wn_q       <= 1'b1;
      wd_q       <= '0;
    end else begin
      ack_q     <= '0;
      ack_err_q <= 1'b0;
      if (clr_err) begin
        rb_error_q <= 1'b0;
        err_cnt_q  <= '0;
      end
      case (state_q)
        S_IDLE: begin
          if (grant_vld) begin
            gnt_q   <= grant_idx;
            data_q  <= grant_data;
            wd_q    <= wd_ext;
            cs_q    <= 1'b1;
            wn_q    <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= S_WRITE;
          end
        end
        S_WRITE: begin
          wn_q    <= 1'b1;
          state_q <= S_READ;
        end
        S_READ: begin
          // Read data is valid combinationally during READ; ack shows in DONE.
          cs_q         <= 1'b0;
          mis_q        <= mismatch;
          ack_q[gnt_q] <= 1'b1;
          ack_err_q    <= mismatch;
          state_q      <= S_DONE;
        end
        S_DONE: begin
          rr_ptr_q <= rr_next;
          // A clear in this same cycle overrides the error update.
          if (mis_q && !clr_err) begin
            rb_error_q <= 1'b1;
            if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
          end
          if (MIN_GAP > 0) begin
            gap_q   <= 8'(MIN_GAP - 1);
            state_q <= S_GAP;
          end else begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        S_GAP: begin
          if (gap_q == '0) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            gap_q <= gap_q - 8'd1;
          end
        end
        default: begin
          cs_q    <= 1'b0;
          wn_q    <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign ack           = ack_q;
  assign ack_err       = ack_err_q;
  assign busy          = busy_q;
  assign rb_error      = rb_error_q;
  assign err_cnt       = err_cnt_q;
  assign av_address    = 2'b00;
  assign av_chipselect = cs_q;
  assign av_write_n    = wn_q;
  assign av_writedata  = wd_q;

endmodule

// File: tb/tb_anemo_pio_write_arbiter.sv
// Directed bench for anemo_pio_write_arbiter: one instance with no gap and
// one with MIN_GAP=4 share stimulus; each talks to its own echoing PIO model.
module tb_anemo_pio_write_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req;
  logic [15:0] req_data;
  logic        clr_err;
  logic        force_en;
  logic [31:0] force_val;

  logic [1:0]  ack0, ack4;
  logic        ack_err0, ack_err4, busy0, busy4, rb0, rb4, cs0, cs4, wn0, wn4;
  logic [7:0]  cnt0, cnt4;
  logic [1:0]  addr0, addr4;
  logic [31:0] wd0, wd4, rd0, rd4;
  logic [31:0] pio0 = '0;
  logic [31:0] pio4 = '0;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  anemo_pio_write_arbiter #(.NUM_REQ(2), .DATA_W(8), .MIN_GAP(0)) dut0 (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data),
    .ack(ack0), .ack_err(ack_err0), .busy(busy0), .rb_error(rb0),
    .err_cnt(cnt0), .clr_err(clr_err), .av_address(addr0),
    .av_chipselect(cs0), .av_write_n(wn0), .av_writedata(wd0),
    .av_readdata(rd0));

  anemo_pio_write_arbiter #(.NUM_REQ(2), .DATA_W(8), .MIN_GAP(4)) dut4 (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data),
    .ack(ack4), .ack_err(ack_err4), .busy(busy4), .rb_error(rb4),
    .err_cnt(cnt4), .clr_err(clr_err), .av_address(addr4),
    .av_chipselect(cs4), .av_write_n(wn4), .av_writedata(wd4),
    .av_readdata(rd4));

  // PIO models: store writes, echo the low byte with junk in the upper bits.
  always @(posedge clk) begin
    if (cs0 && !wn0) pio0 <= wd0;
    if (cs4 && !wn4) pio4 <= wd4;
  end
  assign rd0 = force_en ? force_val : {24'hC0FFEE, pio0[7:0]};
  assign rd4 = force_en ? force_val : {24'hC0FFEE, pio4[7:0]};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    req      = '0;
    clr_err  = 1'b0;
    force_en = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    int n;
    int cyc;
    logic [1:0] exp_ack;
    reset = 1'b1; req = '0; req_data = '0; clr_err = 1'b0;
    force_en = 1'b0; force_val = '0;

    // Reset state
    tick();
    chk("rst_busy", busy0, 0);
    chk("rst_cs", cs0, 0);
    chk("rst_wn", wn0, 1);
    chk("rst_ack", ack0, 0);
    chk("rst_ackerr", ack_err0, 0);
    chk("rst_rb", rb0, 0);
    chk("rst_cnt", cnt0, 0);
    chk("rst_addr", addr0, 0);
    chk("rst_wd", wd0, 0);

    // T1: single write, echo read-back
    do_reset();
    req_data = 16'h005A; req = 2'b01;
    tick();
    chk("t1_c1_wd", wd0, 32'h0000005A);
    chk("t1_c1_wn", wn0, 0);
    chk("t1_c1_cs", cs0, 1);
    chk("t1_c1_busy", busy0, 1);
    tick();
    chk("t1_c2_cs", cs0, 1);
    chk("t1_c2_wn", wn0, 1);
    tick();
    chk("t1_c3_ack", ack0, 2'b01);
    chk("t1_c3_ackerr", ack_err0, 0);
    chk("t1_c3_cs", cs0, 0);
    req = 2'b00;
    tick();
    chk("t1_c4_busy", busy0, 0);
    chk("t1_c4_ack", ack0, 0);

    // T2: MIN_GAP=4, both requesting from reset
    do_reset();
    req_data = 16'h2211; req = 2'b11;
    tick();
    chk("t2_c1_wd", wd4, 32'h11);
    chk("t2_c1_cs", cs4, 1);
    tick(); tick();
    chk("t2_c3_ack", ack4, 2'b01);
    req = 2'b10;
    tick();
    chk("t2_c4_busy", busy4, 1);
    chk("t2_c4_cs", cs4, 0);
    chk("t2_c4_ack", ack4, 0);
    tick(); tick(); tick();
    chk("t2_c7_busy", busy4, 1);
    chk("t2_c7_cs", cs4, 0);
    tick();
    chk("t2_c8_busy", busy4, 0);
    tick();
    chk("t2_c9_wd", wd4, 32'h22);
    chk("t2_c9_wn", wn4, 0);
    chk("t2_c9_cs", cs4, 1);
    tick(); tick();
    chk("t2_c11_ack", ack4, 2'b10);
    req = 2'b00;

    // T3: continuous requests alternate every 4 cycles
    do_reset();
    req_data = 16'hB2A1; req = 2'b11;
    for (int k = 1; k <= 16; k++) begin
      tick();
      exp_ack = 2'b00;
      if (k % 4 == 3) exp_ack = ((k / 4) % 2 == 0) ? 2'b01 : 2'b10;
      chk($sformatf("t3_ack_c%0d", k), ack0, exp_ack);
      if (k % 4 == 1)
        chk($sformatf("t3_wd_c%0d", k), wd0, ((k / 4) % 2 == 0) ? 32'hA1 : 32'hB2);
    end
    req = 2'b00;

    // T4: forced mismatch, clear, clear-wins, saturation
    do_reset();
    force_en = 1'b1; force_val = 32'h0;
    req_data = 16'h00FF; req = 2'b01;
    tick(); tick(); tick();
    chk("t4_ack", ack0, 2'b01);
    chk("t4_ackerr", ack_err0, 1);
    req = 2'b00;
    tick();
    chk("t4_rb_set", rb0, 1);
    chk("t4_cnt1", cnt0, 1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("t4_rb_clr", rb0, 0);
    chk("t4_cnt_clr", cnt0, 0);
    req = 2'b01;
    tick(); tick(); tick();
    chk("t4_cw_ackerr", ack_err0, 1);
    clr_err = 1'b1; req = 2'b00;
    tick();
    clr_err = 1'b0;
    chk("t4_cw_rb", rb0, 0);
    chk("t4_cw_cnt", cnt0, 0);
    req = 2'b01;
    n = 0; cyc = 0;
    while (n < 300 && cyc < 2000) begin
      tick();
      cyc++;
      if (ack0[0] === 1'b1) n++;
    end
    req = 2'b00;
    chk("t4_ack_count", n, 300);
    tick();
    chk("t4_sat_cnt", cnt0, 8'd255);
    chk("t4_sat_rb", rb0, 1);
    force_en = 1'b0;

    // T5: reset in READ aborts; next grant searches from rr_ptr=0
    do_reset();
    req_data = 16'h4433; req = 2'b01;
    tick(); tick();
    chk("t5_in_read_cs", cs0, 1);
    reset = 1'b1;
    tick();
    chk("t5_abort_cs", cs0, 0);
    chk("t5_abort_wn", wn0, 1);
    chk("t5_abort_busy", busy0, 0);
    chk("t5_abort_ack", ack0, 0);
    reset = 1'b0; req = 2'b10;
    tick();
    chk("t5_c1_wd", wd0, 32'h44);
    chk("t5_c1_ack", ack0, 0);
    tick(); tick();
    chk("t5_c3_ack", ack0, 2'b10);
    req = 2'b00;
    tick();

    // T6: req dropped and data changed after grant
    do_reset();
    req_data = 16'h003C; req = 2'b01;
    tick();
    req = 2'b00; req_data = 16'h00C3;
    tick(); tick();
    chk("t6_ack", ack0, 2'b01);
    chk("t6_ackerr", ack_err0, 0);
    tick();
    chk("t6_busy", busy0, 0);
    chk("t6_rb", rb0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
